pipe_ctrl: RTL

//  Central pipeline controller for the 5-stage core. Merges per-stage stall requests into the

---
 rtl/pipe_ctrl.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/pipe_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_ctrl
//   Central pipeline controller for the 5-stage core. It merges the per-stage
//   stall requests into one stall vector for the pc and stage registers. It
//   also sequences exception and eret redirects: a one-cycle flush pulse that
//   carries the redirect PC, followed by a refill window.
//
//   Optional feature: define PIPE_CTRL_PERF_CNT_EN to add the stall_cycles
//   performance counter port. Without the macro the port and counter are absent.
//
// Parameters
//   ADDR_W         width of the PC / redirect address
//   REFILL_CYCLES  number of cycles spent in REFILL after a flush (1..15)
//   CNT_W          width of stall_cycles (PIPE_CTRL_PERF_CNT_EN only)
//
// Ports
//   clk            rising-edge clock
//   rst            synchronous reset, active-high
//   stallreq_if    fetch not ready (instruction memory wait)
//   stallreq_id    decode hazard (load-use)
//   stallreq_ex    execute multi-cycle op busy
//   stallreq_mem   data memory wait
//   excp_valid     exception committed in MEM this cycle
//   excp_vector    handler entry address
//   eret_valid     eret committed in MEM this cycle
//   epc            return address for eret
//   stall[5:0]     [0]pc [1]if_id [2]id_ex [3]ex_mem [4]mem_wb [5]wb, 1 = hold
//   flush          clear all stage registers to bubble
//   new_pc         redirect target, valid only with new_pc_valid
//   new_pc_valid   pc loads new_pc on this edge
//   state_o        current FSM state (debug)
//   stall_cycles   saturating count of cycles with stall[0]=1 (optional)
// ---------------------------------------------------------------------------
// state  | meaning
// RUN    | normal flow; accepts exception / eret redirects
// FLUSH  | one cycle: flush + new_pc_valid, stall forced low
// REFILL | pipeline refilling; redirects dropped; down-counter to RUN
// (3)    | unused encoding, recovers to RUN, outputs as RUN
// ---------------------------------------------------------------------------
module pipe_ctrl #(
    parameter int ADDR_W        = 32,
    parameter int REFILL_CYCLES = 2,
    parameter int CNT_W         = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stallreq_if,
    input  logic              stallreq_id,
    input  logic              stallreq_ex,
    input  logic              stallreq_mem,
    input  logic              excp_valid,
    input  logic [ADDR_W-1:0] excp_vector,
    input  logic              eret_valid,
    input  logic [ADDR_W-1:0] epc,
    output logic [5:0]        stall,
    output logic              flush,
    output logic [ADDR_W-1:0] new_pc,
    output logic              new_pc_valid,
    output logic [1:0]        state_o
`ifdef PIPE_CTRL_PERF_CNT_EN
    ,
    output logic [CNT_W-1:0]  stall_cycles
`endif
);

    // Elaboration-time parameter sanity checks.
    generate
        if (REFILL_CYCLES < 1 || REFILL_CYCLES > 15) begin : g_bad_refill
            $error("pipe_ctrl: REFILL_CYCLES must be in 1..15");
        end
        if (CNT_W < 1) begin : g_bad_cnt_w
            $error("pipe_ctrl: CNT_W must be at least 1");
        end
        if (ADDR_W < 1) begin : g_bad_addr_w
            $error("pipe_ctrl: ADDR_W must be at least 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_RUN    = 2'd0,
        ST_FLUSH  = 2'd1,
        ST_REFILL = 2'd2,
        ST_RSVD   = 2'd3
    } state_t;

    // FLUSH loads REFILL_CYCLES-1, so REFILL lasts exactly REFILL_CYCLES cycles
    // because the terminal count of zero is itself one REFILL cycle.
    localparam logic [3:0] REFILL_LOAD = 4'(REFILL_CYCLES - 1);

    state_t            state_q, state_d;
    logic [3:0]        refill_cnt_q, refill_cnt_d;
    logic [ADDR_W-1:0] new_pc_q, new_pc_d;
    logic [5:0]        stall_req;

    // -----------------------------------------------------------------------
    // Stall request merge: the deepest stalled stage wins and freezes every
    // stage upstream of it. Purely combinational, so a request holds the
    // pipeline in the same cycle it is raised.
    // -----------------------------------------------------------------------
    always_comb begin
        stall_req = 6'b000000;
        if (stallreq_mem) begin
            stall_req = 6'b011111;
        end else if (stallreq_ex) begin
            stall_req = 6'b001111;
        end else if (stallreq_id) begin
            stall_req = 6'b000111;
        end else if (stallreq_if) begin
            stall_req = 6'b000011;
        end
    end

    // -----------------------------------------------------------------------
    // State register
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_RUN;
            refill_cnt_q <= 4'd0;
            new_pc_q     <= '0;
        end else begin
            state_q      <= state_d;
            refill_cnt_q <= refill_cnt_d;
            new_pc_q     <= new_pc_d;
        end
    end

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        refill_cnt_d = refill_cnt_q;
        new_pc_d     = new_pc_q;
        unique case (state_q)
            ST_RUN: begin
                // The exception wins over eret when both commit together;
                // either one wins over any stall request.
                if (excp_valid) begin
                    state_d  = ST_FLUSH;
                    new_pc_d = excp_vector;
                end else if (eret_valid) begin
                    state_d  = ST_FLUSH;
                    new_pc_d = epc;
                end
            end
            ST_FLUSH: begin
                state_d      = ST_REFILL;
                refill_cnt_d = REFILL_LOAD;
            end
            ST_REFILL: begin
                // Redirects arriving here are dropped on purpose: the
                // instructions raising them are wrong-path leftovers.
                if (refill_cnt_q == 4'd0) begin
                    state_d = ST_RUN;
                end else begin
                    refill_cnt_d = refill_cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Output logic. flush / new_pc_valid decode the registered state, giving
    // the one-cycle latency from the accepting edge.
    // -----------------------------------------------------------------------
    always_comb begin
        stall        = stall_req;
        flush        = 1'b0;
        new_pc_valid = 1'b0;
        new_pc       = new_pc_q;
        state_o      = state_q;
        if (state_q == ST_FLUSH) begin
            stall        = 6'b000000;
            flush        = 1'b1;
            new_pc_valid = 1'b1;
        end
    end

`ifdef PIPE_CTRL_PERF_CNT_EN
    // -----------------------------------------------------------------------
    // Stall cycle counter: counts cycles with the pc held and saturates at
    // all-ones so that a long soak never wraps back to a small value.
    // -----------------------------------------------------------------------
    logic [CNT_W-1:0] stall_cycles_q, stall_cycles_d;

    always_comb begin
        stall_cycles_d = stall_cycles_q;
        if (stall[0] && (stall_cycles_q != {CNT_W{1'b1}})) begin
            stall_cycles_d = stall_cycles_q + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cycles_q <= '0;
        end else begin
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign stall_cycles = stall_cycles_q;
`endif

endmodule
